// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index and hazard FSM state.
package pipe_hazard_ctrl_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic {
    HZ_RUN,
    HZ_BUBBLE
  } lc3b_hz_state;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signals. The pipeline (master) presents ID/EX fields and
// memory handshake status; the controller (slave) returns PC/stage load and flush controls.
import pipe_hazard_ctrl_pkg::*;

interface pipe_hazard_ctrl_if;
  lc3b_reg id_src1;
  lc3b_reg id_src2;
  logic    id_use1;
  logic    id_use2;
  lc3b_reg ex_dest;
  logic    ex_mem_read;
  // A request is outstanding while req=1; resp=1 in the same cycle marks it complete.
  logic    imem_req;
  logic    imem_resp;
  logic    dmem_req;
  logic    dmem_resp;
  logic    br_taken;
  logic    pc_load;
  logic    load_if_id;
  logic    load_id_ex;
  logic    load_ex_mem;
  logic    load_mem_wb;
  logic    flush_if_id;
  logic    flush_id_ex;
  logic    flush_ex_mem;

  modport master (
    output id_src1, id_src2, id_use1, id_use2, ex_dest, ex_mem_read,
           imem_req, imem_resp, dmem_req, dmem_resp, br_taken,
    input  pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem
  );

  modport slave (
    input  id_src1, id_src2, id_use1, id_use2, ex_dest, ex_mem_read,
           imem_req, imem_resp, dmem_req, dmem_resp, br_taken,
    output pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use bubble insertion, branch flush,
// plus saturating stall/bubble/flush counters. state/bub_left are exported for observation.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output lc3b_hz_state         state,
  output logic [1:0]           bub_left
);

  logic mem_busy;
  logic hazard;
  logic stall_inc;
  logic bubble_inc;
  logic flush_inc;

  assign mem_busy = (hz.imem_req & ~hz.imem_resp) | (hz.dmem_req & ~hz.dmem_resp);
  assign hazard   = hz.ex_mem_read &
                    ((hz.id_use1 & (hz.id_src1 == hz.ex_dest)) |
                     (hz.id_use2 & (hz.id_src2 == hz.ex_dest)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HZ_RUN;
      bub_left <= 2'd0;
    end else if (mem_busy) begin
      state    <= state;
      bub_left <= bub_left;
    end else if (hz.br_taken) begin
      // The branch is older than anything being bubbled, so it cancels the bubble run.
      state    <= HZ_RUN;
      bub_left <= 2'd0;
    end else if (state == HZ_BUBBLE) begin
      bub_left <= bub_left - 2'd1;
      if (bub_left == 2'd1)
        state <= HZ_RUN;
    end else if (hazard) begin
      state    <= (LU_BUBBLES == 1) ? HZ_RUN : HZ_BUBBLE;
      bub_left <= 2'(LU_BUBBLES - 1);
    end
  end

  always_comb begin
    hz.pc_load      = 1'b0;
    hz.load_if_id   = 1'b0;
    hz.load_id_ex   = 1'b0;
    hz.load_ex_mem  = 1'b0;
    hz.load_mem_wb  = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.flush_ex_mem = 1'b0;
    stall_inc       = 1'b0;
    bubble_inc      = 1'b0;
    flush_inc       = 1'b0;
    if (reset) begin
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
    end else if (mem_busy) begin
      stall_inc = 1'b1;
    end else if (hz.br_taken) begin
      hz.pc_load      = 1'b1;
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
      hz.load_mem_wb  = 1'b1;
      flush_inc       = 1'b1;
    end else if ((state == HZ_BUBBLE) || hazard) begin
      // Hold PC and IF/ID, zero ID/EX, let older instructions drain.
      hz.flush_id_ex = 1'b1;
      hz.load_ex_mem = 1'b1;
      hz.load_mem_wb = 1'b1;
      bubble_inc     = 1'b1;
    end else begin
      hz.pc_load     = 1'b1;
      hz.load_if_id  = 1'b1;
      hz.load_id_ex  = 1'b1;
      hz.load_ex_mem = 1'b1;
      hz.load_mem_wb = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset(reset), .inc(bubble_inc), .count(bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a LU_BUBBLES=2/16-bit instance plus a
// LU_BUBBLES=1/4-bit instance fed the same inputs for single-bubble and saturation cases.
`timescale 1ns/1ps
import pipe_hazard_ctrl_pkg::*;

module tb_pipe_hazard_ctrl;

  // {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [7:0] C_RST   = 8'b00000_111;
  localparam logic [7:0] C_RUN   = 8'b11111_000;
  localparam logic [7:0] C_BUB   = 8'b00011_010;
  localparam logic [7:0] C_STALL = 8'b00000_000;
  localparam logic [7:0] C_BR    = 8'b10001_111;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if hz ();
  pipe_hazard_ctrl_if hz4 ();

  logic [15:0]  stall_cnt, bubble_cnt, flush_cnt;
  logic [3:0]   stall_cnt4, bubble_cnt4, flush_cnt4;
  lc3b_hz_state state, state4;
  logic [1:0]   bub_left, bub_left4;
  logic [7:0]   ctrl;

  logic [7:0] exp_q[$];
  int n_tests;
  int n_fail;

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .hz(hz),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .state(state), .bub_left(bub_left)
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .hz(hz4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4),
    .state(state4), .bub_left(bub_left4)
  );

  assign hz4.id_src1     = hz.id_src1;
  assign hz4.id_src2     = hz.id_src2;
  assign hz4.id_use1     = hz.id_use1;
  assign hz4.id_use2     = hz.id_use2;
  assign hz4.ex_dest     = hz.ex_dest;
  assign hz4.ex_mem_read = hz.ex_mem_read;
  assign hz4.imem_req    = hz.imem_req;
  assign hz4.imem_resp   = hz.imem_resp;
  assign hz4.dmem_req    = hz.dmem_req;
  assign hz4.dmem_resp   = hz.dmem_resp;
  assign hz4.br_taken    = hz.br_taken;

  assign ctrl = {hz.pc_load, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem, hz.load_mem_wb,
                 hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_hz(input lc3b_reg s1, input logic u1, input lc3b_reg s2, input logic u2,
                        input lc3b_reg dest, input logic mrd);
    hz.id_src1 = s1; hz.id_use1 = u1;
    hz.id_src2 = s2; hz.id_use2 = u2;
    hz.ex_dest = dest; hz.ex_mem_read = mrd;
  endtask

  task automatic set_mem(input logic ireq, input logic iresp, input logic dreq, input logic dresp);
    hz.imem_req = ireq; hz.imem_resp = iresp;
    hz.dmem_req = dreq; hz.dmem_resp = dresp;
  endtask

  // Check the combinational controls for the current cycle, then advance one clock.
  task automatic step(input string tag, input logic [7:0] exp_ctrl);
    logic [7:0] e;
    exp_q.push_back(exp_ctrl);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'(ctrl), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    hz.br_taken = 1'b0;
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    set_mem(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // reset held two cycles, with a pending stall on the inputs to prove reset wins
    set_mem(1'b1, 1'b0, 1'b0, 1'b0);
    step("reset_ctrl0", C_RST);
    step("reset_ctrl1", C_RST);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    check("reset_state", 32'(state), 32'(HZ_RUN));
    set_mem(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("post_reset_run", C_RUN);

    // load-use on SR1 with two bubbles
    set_hz(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
    step("lu_bub0", C_BUB);
    check("lu_state_bubble", 32'(state), 32'(HZ_BUBBLE));
    check("lu_bub_left", 32'(bub_left), 32'd1);
    step("lu_bub1", C_BUB);
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("lu_state_run", 32'(state), 32'(HZ_RUN));
    step("lu_resume", C_RUN);
    check("lu_bubble_cnt", 32'(bubble_cnt), 32'd2);
    check("lu1_bubble_cnt", 32'(bubble_cnt4), 32'd2);

    // data-memory wait in the middle of a bubble run
    set_hz(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
    step("mid_bub0", C_BUB);
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    set_mem(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("dmem_stall", C_STALL);
      check("stall_bub_left", 32'(bub_left), 32'd1);
    end
    check("stall_state", 32'(state), 32'(HZ_BUBBLE));
    check("stall_cnt5", 32'(stall_cnt), 32'd5);
    set_mem(1'b0, 1'b0, 1'b1, 1'b1);
    step("bub_after_resp", C_BUB);
    set_mem(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_resp_state", 32'(state), 32'(HZ_RUN));
    step("after_resp_run", C_RUN);
    check("after_resp_bubble_cnt", 32'(bubble_cnt), 32'd4);

    // taken branch beats a simultaneous load-use hazard
    set_hz(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
    hz.br_taken = 1'b1;
    step("br_over_hazard", C_BR);
    hz.br_taken = 1'b0;
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("br_state", 32'(state), 32'(HZ_RUN));
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_bubble_cnt", 32'(bubble_cnt), 32'd4);
    // taken branch aborts a bubble run
    set_hz(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
    step("pre_abort_bub", C_BUB);
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    hz.br_taken = 1'b1;
    step("br_abort", C_BR);
    check("abort_state", 32'(state), 32'(HZ_RUN));
    check("abort_bub_left", 32'(bub_left), 32'd0);
    // memory wait beats a taken branch
    set_mem(1'b1, 1'b0, 1'b0, 1'b0);
    step("busy_over_br", C_STALL);
    hz.br_taken = 1'b0;
    set_mem(1'b0, 1'b0, 1'b0, 1'b0);
    step("post_br_run", C_RUN);
    check("br2_flush_cnt", 32'(flush_cnt), 32'd2);
    check("br2_stall_cnt", 32'(stall_cnt), 32'd6);
    check("br2_bubble_cnt", 32'(bubble_cnt), 32'd5);

    // SR2 match ignored while id_use2=0, honoured once set
    set_hz(3'd5, 1'b1, 3'd3, 1'b0, 3'd3, 1'b1);
    step("src2_unused", C_RUN);
    set_hz(3'd5, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1);
    step("src2_used", C_BUB);
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("src2_bub1", C_BUB);
    // R0 is an ordinary destination; no hazard without a load
    set_hz(3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("r0_no_load", C_RUN);
    set_hz(3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1);
    step("r0_bub0", C_BUB);
    step("r0_bub1", C_BUB);
    set_hz(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("r0_resume", C_RUN);
    check("r0_bubble_cnt", 32'(bubble_cnt), 32'd9);
    check("lu1_bubble_cnt2", 32'(bubble_cnt4), 32'd7);

    // long fetch wait: 16-bit counter keeps counting, 4-bit counter saturates
    set_mem(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("long_stall_ctrl", 32'(ctrl), 32'(C_STALL));
      @(posedge clk); #1;
    end
    set_mem(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_stall_cnt16", 32'(stall_cnt), 32'd26);
    check("sat_stall_cnt4", 32'(stall_cnt4), 32'hF);
    check("sat_flush_cnt4", 32'(flush_cnt4), 32'd2);
    step("sat_resume", C_RUN);
    check("sat_stall_hold", 32'(stall_cnt4), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
